// File: rtl/repl_fill_regbank.sv
// ---------------------------------------------------------------------------
// repl_fill_regbank
//   Bank of CHANNELS registers, WIDTH bits each, updated through a
//   valid/ready command port. Supported operations:
//     LOAD  : reg[ch] <= cmd_data
//     FILL  : reg[ch] <= {SLOTS{cmd_pat}}
//     SHIFT : reg[ch] <= {reg[ch] minus its top PAT_W bits, cmd_pat}
//     SWEEP : multi-cycle; writes cmd_pat into one PAT_W slot per cycle,
//             starting at the LSB slot, until every slot has been written
//   Every register resets asynchronously to {SLOTS{RST_PAT}}.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command valid
//   cmd_ready  command accepted when cmd_valid && cmd_ready (high in IDLE)
//   cmd_op     0 LOAD, 1 FILL, 2 SHIFT, 3 SWEEP
//   cmd_ch     target channel; out-of-range drops the op and pulses err
//   cmd_data   LOAD data
//   cmd_pat    pattern for FILL / SHIFT / SWEEP
//   regs_o     register contents, channel c at [c*WIDTH +: WIDTH]
//   busy       SWEEP in progress
//   done       1-cycle pulse on completion of each accepted op
//   err        1-cycle pulse on an out-of-range channel
// ---------------------------------------------------------------------------
module repl_fill_regbank #(
    parameter int unsigned        WIDTH    = 32,
    parameter int unsigned        PAT_W    = 2,
    parameter int unsigned        CHANNELS = 4,
    parameter logic [PAT_W-1:0]   RST_PAT  = '0,
    localparam int unsigned       CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [CH_W-1:0]              cmd_ch,
    input  logic [WIDTH-1:0]             cmd_data,
    input  logic [PAT_W-1:0]             cmd_pat,
    output logic [CHANNELS*WIDTH-1:0]    regs_o,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned SLOTS = WIDTH / PAT_W;
    localparam int unsigned K_W   = $clog2(SLOTS) + 1;

    generate
        if ((WIDTH % PAT_W) != 0) begin : g_bad_width
            $error("repl_fill_regbank: WIDTH must be a multiple of PAT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_FILL  = 2'd1,
        OP_SHIFT = 2'd2,
        OP_SWEEP = 2'd3
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    regs_q [CHANNELS];
    logic [CH_W-1:0]     sw_ch;
    logic [PAT_W-1:0]    sw_pat;
    logic [K_W-1:0]      sw_k;
    logic                ch_ok;

    assign cmd_ready = (state == S_IDLE);
    assign ch_ok     = (32'(cmd_ch) < CHANNELS);

    always_comb begin
        regs_o = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            regs_o[c*WIDTH +: WIDTH] = regs_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                regs_q[c] <= {SLOTS{RST_PAT}};
            end
            state  <= S_IDLE;
            sw_ch  <= '0;
            sw_pat <= '0;
            sw_k   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (!ch_ok) begin
                            err <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_LOAD: begin
                                    regs_q[cmd_ch] <= cmd_data;
                                    done           <= 1'b1;
                                end
                                OP_FILL: begin
                                    regs_q[cmd_ch] <= {SLOTS{cmd_pat}};
                                    done           <= 1'b1;
                                end
                                OP_SHIFT: begin
                                    // Shift form avoids a negative slice when PAT_W == WIDTH;
                                    // in that case the result degenerates to a fill.
                                    regs_q[cmd_ch] <= (regs_q[cmd_ch] << PAT_W) | WIDTH'(cmd_pat);
                                    done           <= 1'b1;
                                end
                                OP_SWEEP: begin
                                    sw_ch  <= cmd_ch;
                                    sw_pat <= cmd_pat;
                                    sw_k   <= '0;
                                    busy   <= 1'b1;
                                    state  <= S_SWEEP;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_SWEEP: begin
                    for (int unsigned s = 0; s < SLOTS; s++) begin
                        if (K_W'(s) == sw_k) begin
                            regs_q[sw_ch][s*PAT_W +: PAT_W] <= sw_pat;
                        end
                    end
                    if (sw_k == K_W'(SLOTS - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sw_k <= sw_k + K_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
